// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions for the training-sequence generator.
// Holds the 8b/10b symbol codes, the ordered-set width, the TS1/TS2 kind
// encoding, the generator state enum and the latched configuration record.
package ltssm_pkg;

  localparam logic [7:0] COM    = 8'hBC;  // K28.5 comma
  localparam logic [7:0] PADG12 = 8'hF7;  // K23.7 PAD
  localparam logic [7:0] D10_2  = 8'h4A;  // TS1 identifier
  localparam logic [7:0] D5_2   = 8'h45;  // TS2 identifier

  localparam int TS_W = 128;              // one ordered set = 16 symbols

  typedef enum logic {
    TS_KIND_TS1 = 1'b0,
    TS_KIND_TS2 = 1'b1
  } ts_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SEND     = 2'd1,
    ST_STOPPING = 2'd2
  } ts_state_e;

  typedef struct packed {
    ts_kind_e   kind;
    logic       link_pad;
    logic [7:0] link_num;
    logic       lane_pad;
    logic [7:0] lane_base;
    logic [7:0] n_fts;
    logic [5:0] rate;
    logic [7:0] train_ctl;
  } ts_cfg_t;

  function automatic logic [7:0] ts_id_sym(input ts_kind_e kind);
    return (kind == TS_KIND_TS2) ? D5_2 : D10_2;
  endfunction

endpackage

// File: rtl/ts_sym_build.sv
// Combinational builder for one TS1/TS2 ordered set.
// Ports:
//   cfg_i : latched generator configuration
//   set_o : 128-bit ordered set, symbol 0 (COM) in the MSBs, symbol 15 in the LSBs
// Parameter LANE selects the lane offset added to the configured lane base.
module ts_sym_build
  import ltssm_pkg::*;
#(
  parameter int LANE = 0
) (
  input  ts_cfg_t           cfg_i,
  output logic [TS_W-1:0]   set_o
);

  // Lane numbers wrap modulo 256.
  localparam logic [7:0] LANE_OFS = 8'(LANE % 256);

  logic [7:0] id_sym;
  logic [7:0] link_sym;
  logic [7:0] lane_sym;

  always_comb begin
    id_sym   = ts_id_sym(cfg_i.kind);
    link_sym = cfg_i.link_pad ? PADG12 : cfg_i.link_num;
    lane_sym = cfg_i.lane_pad ? PADG12 : (cfg_i.lane_base + LANE_OFS);
    set_o    = {COM, link_sym, lane_sym, cfg_i.n_fts, {2'b00, cfg_i.rate},
                cfg_i.train_ctl, {10{id_sym}}};
  end

endmodule

// File: rtl/ts_os_gen.sv
// Training-sequence ordered-set generator feeding the TX TS FIFO.
// Latches a TS1/TS2 configuration on ts_start, streams one ordered set per
// lane per beat over ts_valid/tx_ready, and counts accepted beats against a
// programmable target.
// Ports:
//   clk, rst          : clock, asynchronous active-high reset
//   ts_start, ts_stop : (re)start with fresh config / stop after in-flight beat
//   cfg_*             : ordered-set fields and count target, sampled on ts_start
//   tx_ready          : downstream accepts the current beat
//   ts_valid, ts      : beat handshake and NUM_LANES x 128-bit ordered sets
//   ts_sent_cnt       : accepted beats since last start (saturating)
//   ts_sent_enough    : sticky, count has reached target
//   busy              : generator not idle
module ts_os_gen
  import ltssm_pkg::*;
#(
  parameter int NUM_LANES = 1,
  parameter int CNT_W     = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ts_start,
  input  logic                      ts_stop,
  input  logic                      cfg_ts2,
  input  logic                      cfg_link_pad,
  input  logic [7:0]                cfg_link_num,
  input  logic                      cfg_lane_pad,
  input  logic [7:0]                cfg_lane_base,
  input  logic [7:0]                cfg_n_fts,
  input  logic [5:0]                cfg_rate,
  input  logic [7:0]                cfg_train_ctl,
  input  logic [CNT_W-1:0]          cfg_target,
  input  logic                      tx_ready,
  output logic                      ts_valid,
  output logic [TS_W*NUM_LANES-1:0] ts,
  output logic [CNT_W-1:0]          ts_sent_cnt,
  output logic                      ts_sent_enough,
  output logic                      busy
);

  ts_state_e                 state_q, state_d;
  ts_cfg_t                   cfg_q;
  logic [CNT_W-1:0]          target_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      enough_q, enough_d;
  logic                      accept;
  logic [TS_W*NUM_LANES-1:0] sets;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Configuration is data: captured on every start, no reset needed because
  // the output is gated by the state register.
  always_ff @(posedge clk) begin
    if (ts_start) begin
      cfg_q.kind      <= ts_kind_e'(cfg_ts2);
      cfg_q.link_pad  <= cfg_link_pad;
      cfg_q.link_num  <= cfg_link_num;
      cfg_q.lane_pad  <= cfg_lane_pad;
      cfg_q.lane_base <= cfg_lane_base;
      cfg_q.n_fts     <= cfg_n_fts;
      cfg_q.rate      <= cfg_rate;
      cfg_q.train_ctl <= cfg_train_ctl;
      target_q        <= cfg_target;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    ts_sym_build #(.LANE(k)) u_sym (
      .cfg_i (cfg_q),
      .set_o (sets[TS_W*k +: TS_W])
    );
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:     if (ts_start) state_d = ST_SEND;
      ST_SEND: begin
        if (ts_start)     state_d = ST_SEND;
        else if (ts_stop) state_d = tx_ready ? ST_IDLE : ST_STOPPING;
      end
      // Hold the pending beat until it is taken; a start restarts instead.
      ST_STOPPING: begin
        if (ts_start)      state_d = ST_SEND;
        else if (tx_ready) state_d = ST_IDLE;
      end
      default:     state_d = ST_IDLE;
    endcase
  end

  // A beat taken in the same cycle as a restart belongs to the old run and
  // is not counted against the new target.
  assign accept = ts_valid & tx_ready & ~ts_start;

  always_comb begin
    cnt_d    = cnt_q;
    enough_d = enough_q;
    if (ts_start) begin
      cnt_d    = '0;
      enough_d = (cfg_target == '0);
    end else if (accept) begin
      cnt_d    = sat_inc(cnt_q);
      enough_d = enough_q | (cnt_d >= target_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      enough_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      enough_q <= enough_d;
    end
  end

  assign ts_valid       = (state_q != ST_IDLE);
  assign busy           = ts_valid;
  assign ts             = ts_valid ? sets : '0;
  assign ts_sent_cnt    = cnt_q;
  assign ts_sent_enough = enough_q;

endmodule

// File: tb/tb_ts_os_gen.sv
module tb_ts_os_gen;

  localparam logic [127:0] L0_TS1  = 128'hBC05FE1F0200_4A4A4A4A4A4A4A4A4A4A;
  localparam logic [127:0] L1_TS1  = 128'hBC05FF1F0200_4A4A4A4A4A4A4A4A4A4A;
  localparam logic [127:0] L2_TS1  = 128'hBC05001F0200_4A4A4A4A4A4A4A4A4A4A;
  localparam logic [127:0] L3_TS1  = 128'hBC05011F0200_4A4A4A4A4A4A4A4A4A4A;
  localparam logic [127:0] PAD_TS2 = 128'hBCF7F71F0200_45454545454545454545;
  localparam logic [127:0] L0_2A   = 128'hBC2A001F0200_4A4A4A4A4A4A4A4A4A4A;

  logic clk = 1'b0;
  logic rst;
  logic start, stop, ts2, lpad, lnpad, rdy;
  logic [7:0] link, lbase, nfts, train;
  logic [5:0] rate;
  logic [15:0] target;
  logic valid, enough, busy;
  logic [511:0] ts;
  logic [15:0] cnt;

  logic s_start, s_stop, s_rdy, s_valid, s_enough, s_busy;
  logic [3:0] s_target, s_cnt;
  logic [127:0] s_ts;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ts_os_gen #(.NUM_LANES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .ts_start(start), .ts_stop(stop),
    .cfg_ts2(ts2), .cfg_link_pad(lpad), .cfg_link_num(link),
    .cfg_lane_pad(lnpad), .cfg_lane_base(lbase), .cfg_n_fts(nfts),
    .cfg_rate(rate), .cfg_train_ctl(train), .cfg_target(target),
    .tx_ready(rdy), .ts_valid(valid), .ts(ts), .ts_sent_cnt(cnt),
    .ts_sent_enough(enough), .busy(busy)
  );

  ts_os_gen #(.NUM_LANES(1), .CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .ts_start(s_start), .ts_stop(s_stop),
    .cfg_ts2(ts2), .cfg_link_pad(lpad), .cfg_link_num(link),
    .cfg_lane_pad(lnpad), .cfg_lane_base(lbase), .cfg_n_fts(nfts),
    .cfg_rate(rate), .cfg_train_ctl(train), .cfg_target(s_target),
    .tx_ready(s_rdy), .ts_valid(s_valid), .ts(s_ts), .ts_sent_cnt(s_cnt),
    .ts_sent_enough(s_enough), .busy(s_busy)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid); end
    n_cmp++; if (ts !== '0) begin n_fail++; $display("FAIL reset_ts got %h want 0", ts); end
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt got %0d want 0", cnt); end
    n_cmp++; if (enough !== 1'b0) begin n_fail++; $display("FAIL reset_enough got %b want 0", enough); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    rst = 1'b0;
    step();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got %b want 0", valid); end
  endtask

  task automatic test_ts1_lanes();
    ts2 = 0; lpad = 0; lnpad = 0; link = 8'h05; lbase = 8'hFE;
    nfts = 8'h1F; rate = 6'h02; train = 8'h00; target = 16'd3; rdy = 1;
    start = 1;
    #1;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ts1_valid_before_edge got %b want 0", valid); end
    step();
    start = 0;
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ts1_valid got %b want 1", valid); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL ts1_busy got %b want 1", busy); end
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL ts1_cnt0 got %0d want 0", cnt); end
    n_cmp++; if (ts[127:0] !== L0_TS1) begin n_fail++; $display("FAIL ts1_lane0 got %h want %h", ts[127:0], L0_TS1); end
    n_cmp++; if (ts[255:128] !== L1_TS1) begin n_fail++; $display("FAIL ts1_lane1 got %h want %h", ts[255:128], L1_TS1); end
    n_cmp++; if (ts[383:256] !== L2_TS1) begin n_fail++; $display("FAIL ts1_lane2 got %h want %h", ts[383:256], L2_TS1); end
    n_cmp++; if (ts[511:384] !== L3_TS1) begin n_fail++; $display("FAIL ts1_lane3 got %h want %h", ts[511:384], L3_TS1); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (cnt !== 16'(i)) begin n_fail++; $display("FAIL ts1_cnt got %0d want %0d", cnt, i); end
      n_cmp++; if (enough !== (i >= 3)) begin n_fail++; $display("FAIL ts1_enough got %b want %b at cnt %0d", enough, (i >= 3), i); end
    end
    stop = 1;
    step();
    stop = 0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL ts1_stop_valid got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ts1_stop_busy got %b want 0", busy); end
    n_cmp++; if (cnt !== 16'd4) begin n_fail++; $display("FAIL ts1_stop_cnt got %0d want 4", cnt); end
    n_cmp++; if (ts !== '0) begin n_fail++; $display("FAIL ts1_stop_ts got %h want 0", ts); end
  endtask

  task automatic test_ts2_pad_ready();
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int   exp [4] = '{1, 1, 1, 2};
    ts2 = 1; lpad = 1; lnpad = 1; target = 16'd100; rdy = 0;
    start = 1;
    step();
    start = 0;
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL ts2_cnt0 got %0d want 0", cnt); end
    n_cmp++; if (ts[127:0] !== PAD_TS2) begin n_fail++; $display("FAIL ts2_lane0 got %h want %h", ts[127:0], PAD_TS2); end
    n_cmp++; if (ts[511:384] !== PAD_TS2) begin n_fail++; $display("FAIL ts2_lane3 got %h want %h", ts[511:384], PAD_TS2); end
    for (int i = 0; i < 4; i++) begin
      rdy = pat[i];
      step();
      n_cmp++; if (cnt !== 16'(exp[i])) begin n_fail++; $display("FAIL ts2_toggle_cnt got %0d want %0d step %0d", cnt, exp[i], i); end
      n_cmp++; if (ts !== {4{PAD_TS2}}) begin n_fail++; $display("FAIL ts2_toggle_ts got %h want stable pad set step %0d", ts[127:0], i); end
      n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL ts2_toggle_valid got %b want 1 step %0d", valid, i); end
    end
  endtask

  task automatic test_stop_stalled();
    rdy = 0; stop = 1;
    step();
    stop = 0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (valid !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL stopping_valid got %b/%b want 1/1 cycle %0d", valid, busy, i); end
      n_cmp++; if (ts !== {4{PAD_TS2}}) begin n_fail++; $display("FAIL stopping_ts got %h want held pad set cycle %0d", ts[127:0], i); end
      n_cmp++; if (cnt !== 16'd2) begin n_fail++; $display("FAIL stopping_cnt got %0d want 2 cycle %0d", cnt, i); end
      if (i < 2) step();
    end
    rdy = 1;
    step();
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL stopped_valid got %b want 0", valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stopped_busy got %b want 0", busy); end
    n_cmp++; if (cnt !== 16'd3) begin n_fail++; $display("FAIL stopped_cnt got %0d want 3", cnt); end
    n_cmp++; if (enough !== 1'b0) begin n_fail++; $display("FAIL stopped_enough got %b want 0", enough); end
  endtask

  task automatic test_restart();
    ts2 = 0; lpad = 0; lnpad = 0; link = 8'h05; lbase = 8'h00;
    target = 16'd4; rdy = 1;
    start = 1;
    step();
    start = 0;
    repeat (10) step();
    n_cmp++; if (cnt !== 16'd10) begin n_fail++; $display("FAIL restart_pre_cnt got %0d want 10", cnt); end
    n_cmp++; if (enough !== 1'b1) begin n_fail++; $display("FAIL restart_pre_enough got %b want 1", enough); end
    n_cmp++; if (ts[127:0] !== L2_TS1) begin n_fail++; $display("FAIL restart_pre_lane0 got %h want %h", ts[127:0], L2_TS1); end
    link = 8'h2A;
    start = 1;
    step();
    start = 0;
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL restart_cnt got %0d want 0", cnt); end
    n_cmp++; if (enough !== 1'b0) begin n_fail++; $display("FAIL restart_enough got %b want 0", enough); end
    n_cmp++; if (ts[127:0] !== L0_2A) begin n_fail++; $display("FAIL restart_lane0 got %h want %h", ts[127:0], L0_2A); end
    for (int i = 1; i <= 4; i++) begin
      step();
      n_cmp++; if (cnt !== 16'(i)) begin n_fail++; $display("FAIL restart_cnt_run got %0d want %0d", cnt, i); end
      n_cmp++; if (enough !== (i >= 4)) begin n_fail++; $display("FAIL restart_enough_run got %b want %b at cnt %0d", enough, (i >= 4), i); end
    end
    stop = 1;
    step();
    stop = 0;
    n_cmp++; if (valid !== 1'b0) begin n_fail++; $display("FAIL restart_stop_valid got %b want 0", valid); end
  endtask

  task automatic test_saturation();
    s_target = 4'd15; s_rdy = 1; s_start = 1;
    step();
    s_start = 0;
    n_cmp++; if (s_cnt !== 4'd0 || s_valid !== 1'b1) begin n_fail++; $display("FAIL sat_start got cnt %0d valid %b want 0/1", s_cnt, s_valid); end
    n_cmp++; if (s_ts !== L0_2A) begin n_fail++; $display("FAIL sat_lane0 got %h want %h", s_ts, L0_2A); end
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 14) begin
        n_cmp++; if (s_cnt !== 4'd14 || s_enough !== 1'b0) begin n_fail++; $display("FAIL sat_14 got cnt %0d enough %b want 14/0", s_cnt, s_enough); end
      end
      if (i == 15) begin
        n_cmp++; if (s_cnt !== 4'd15 || s_enough !== 1'b1) begin n_fail++; $display("FAIL sat_15 got cnt %0d enough %b want 15/1", s_cnt, s_enough); end
      end
    end
    n_cmp++; if (s_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_hold_cnt got %0d want 15", s_cnt); end
    n_cmp++; if (s_enough !== 1'b1) begin n_fail++; $display("FAIL sat_hold_enough got %b want 1", s_enough); end
    s_stop = 1;
    step();
    s_stop = 0;
    n_cmp++; if (s_valid !== 1'b0 || s_busy !== 1'b0) begin n_fail++; $display("FAIL sat_stop got valid %b busy %b want 0/0", s_valid, s_busy); end
  endtask

  task automatic test_async_reset();
    target = 16'd7; rdy = 0; start = 1;
    step();
    start = 0;
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL arst_pre_valid got %b want 1", valid); end
    #1 rst = 1;
    #1;
    n_cmp++; if (valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL arst_valid got %b/%b want 0/0", valid, busy); end
    n_cmp++; if (ts !== '0) begin n_fail++; $display("FAIL arst_ts got %h want 0", ts); end
    n_cmp++; if (cnt !== 16'd0 || enough !== 1'b0) begin n_fail++; $display("FAIL arst_cnt got %0d/%b want 0/0", cnt, enough); end
    #1 rst = 0;
    target = 16'd0; rdy = 1; start = 1;
    step();
    start = 0;
    n_cmp++; if (valid !== 1'b1) begin n_fail++; $display("FAIL tgt0_valid got %b want 1", valid); end
    n_cmp++; if (enough !== 1'b1) begin n_fail++; $display("FAIL tgt0_enough got %b want 1", enough); end
    n_cmp++; if (cnt !== 16'd0) begin n_fail++; $display("FAIL tgt0_cnt got %0d want 0", cnt); end
  endtask

  initial begin
    rst = 1; start = 0; stop = 0; ts2 = 0; lpad = 0; lnpad = 0; rdy = 0;
    link = 8'h00; lbase = 8'h00; nfts = 8'h00; rate = 6'h00; train = 8'h00;
    target = 16'd0;
    s_start = 0; s_stop = 0; s_rdy = 0; s_target = 4'd0;
    test_reset();
    test_ts1_lanes();
    test_ts2_pad_ready();
    test_stop_stalled();
    test_restart();
    test_saturation();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
